// File: rtl/cplx_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : cplx_alu_if
//  Description : Request/response bundle between a requester and cplx_alu.
//                The master issues start/op/operands/dst; the slave returns
//                busy/done/result/res_dst.
//  Revision    : 1.0  initial release
// ============================================================================
interface cplx_alu_if;
  logic        start;
  logic [1:0]  op;
  logic [63:0] opA;
  logic [63:0] opB;
  logic [3:0]  dst;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [3:0]  res_dst;

  modport master (
    output start, op, opA, opB, dst,
    input  busy, done, result, res_dst
  );

  modport slave (
    input  start, op, opA, opB, dst,
    output busy, done, result, res_dst
  );
endinterface
`default_nettype wire

// File: rtl/cplx_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cplx_alu
//  Description : Sequential complex-integer ALU (ADD, SUB, MUL, MAG) built
//                around one shared 32x32 multiplier with a start/busy/done
//                handshake. Operands are {re[63:32], im[31:0]}.
//  Option      : define CALU_SAT_EN to saturate ADD/SUB per component;
//                otherwise ADD/SUB wrap. MUL/MAG always wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module cplx_alu (
  input  wire logic   clock,
  input  wire logic   reset,
  cplx_alu_if.slave   bus
);

  localparam logic [1:0] c_OP_SUB = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy;
  logic        w_accept;

  logic [31:0] r_a_re, r_a_im, r_b_re, r_b_im;
  logic [3:0]  r_dst;
  logic        r_mag;
  logic [31:0] r_acc_re, r_acc_im;
  logic [63:0] r_result;
  logic [3:0]  r_res_dst;
  logic        r_done;

  logic [31:0] w_mx, w_my;
  logic [31:0] w_prod;

  // Per-component add/subtract; with saturation, overflow is seen when both
  // addends share a sign that the sum does not.
  function automatic logic [31:0] f_addsub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sub);
    logic [31:0] bb;
    logic [31:0] s;
    bb = sub ? ~b : b;
    s  = a + bb + {31'd0, sub};
`ifdef CALU_SAT_EN
    if ((a[31] == bb[31]) && (s[31] != a[31]))
      s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s;
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; MAG leaves after M1, MUL runs to M3.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.op[1]) w_state_nxt = S_M0;
        end
      end
      S_M0:    w_state_nxt = S_M1;
      S_M1:    w_state_nxt = r_mag ? S_IDLE : S_M2;
      S_M2:    w_state_nxt = S_M3;
      S_M3:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier operand select: one partial product per sequencing state.
  always_comb begin
    w_mx = r_a_re;
    w_my = r_b_re;
    case (r_state)
      S_M0: begin w_mx = r_a_re; w_my = r_mag ? r_a_re : r_b_re; end
      S_M1: begin w_mx = r_a_im; w_my = r_mag ? r_a_im : r_b_im; end
      S_M2: begin w_mx = r_a_re; w_my = r_b_im; end
      S_M3: begin w_mx = r_a_im; w_my = r_b_re; end
      default: ;
    endcase
  end

  // Only the low 32 bits of the signed product are kept; they do not depend
  // on signedness, so a 32-bit-wide product is sufficient.
  assign w_prod = $signed(w_mx) * $signed(w_my);

  // Operand capture, accumulation and result/done registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_re    <= 32'h0;
      r_a_im    <= 32'h0;
      r_b_re    <= 32'h0;
      r_b_im    <= 32'h0;
      r_dst     <= 4'h0;
      r_mag     <= 1'b0;
      r_acc_re  <= 32'h0;
      r_acc_im  <= 32'h0;
      r_result  <= 64'h0;
      r_res_dst <= 4'h0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_re <= bus.opA[63:32];
            r_a_im <= bus.opA[31:0];
            r_b_re <= bus.opB[63:32];
            r_b_im <= bus.opB[31:0];
            r_dst  <= bus.dst;
            r_mag  <= bus.op[0];
            if (!bus.op[1]) begin
              r_result  <= {f_addsub(bus.opA[63:32], bus.opB[63:32], bus.op == c_OP_SUB),
                            f_addsub(bus.opA[31:0],  bus.opB[31:0],  bus.op == c_OP_SUB)};
              r_res_dst <= bus.dst;
              r_done    <= 1'b1;
            end
          end
        end
        S_M0: r_acc_re <= w_prod;
        S_M1: begin
          if (r_mag) begin
            r_acc_re  <= r_acc_re + w_prod;
            r_result  <= {r_acc_re + w_prod, 32'h0};
            r_res_dst <= r_dst;
            r_done    <= 1'b1;
          end else begin
            r_acc_re <= r_acc_re - w_prod;
          end
        end
        S_M2: r_acc_im <= w_prod;
        S_M3: begin
          r_acc_im  <= r_acc_im + w_prod;
          r_result  <= {r_acc_re, r_acc_im + w_prod};
          r_res_dst <= r_dst;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.res_dst = r_res_dst;

endmodule
`default_nettype wire

// File: tb/tb_cplx_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cplx_alu
//  Description : Self-checking bench for cplx_alu: directed cases with literal
//                expectations, then randomized traffic against a cycle model
//                built from plain complex arithmetic and a latency countdown.
//                Honors CALU_SAT_EN for the ADD/SUB expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cplx_alu;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cplx_alu_if bus ();

  cplx_alu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: edges left before the pending op completes, and outputs.
  int          m_rem = 0;
  logic [63:0] m_pend_res = 64'h0;
  logic [3:0]  m_pend_dst = 4'h0;
  logic [63:0] m_result = 64'h0;
  logic [3:0]  m_res_dst = 4'h0;
  logic        m_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_addsub(input logic [31:0] a, input logic [31:0] b, input bit sub);
    longint s;
    s = sub ? (longint'($signed(a)) - longint'($signed(b)))
            : (longint'($signed(a)) + longint'($signed(b)));
`ifdef CALU_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  function automatic logic [63:0] m_eval(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    int ar, ai, br, bi, re, im;
    ar = $signed(a[63:32]); ai = $signed(a[31:0]);
    br = $signed(b[63:32]); bi = $signed(b[31:0]);
    case (op)
      2'd0:    return {m_addsub(a[63:32], b[63:32], 1'b0), m_addsub(a[31:0], b[31:0], 1'b0)};
      2'd1:    return {m_addsub(a[63:32], b[63:32], 1'b1), m_addsub(a[31:0], b[31:0], 1'b1)};
      2'd2: begin
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
      end
      default: begin
        re = ar * ar + ai * ai;
        return {re, 32'h0};
      end
    endcase
  endfunction

  // Behavioural model: advances one clock edge at a time.
  always @(posedge clock) begin
    if (reset) begin
      m_rem = 0; m_done = 1'b0; m_result = 64'h0; m_res_dst = 4'h0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1; m_result = m_pend_res; m_res_dst = m_pend_dst;
        end
      end else if (bus.start) begin
        if (!bus.op[1]) begin
          m_done = 1'b1;
          m_result = m_eval(bus.op, bus.opA, bus.opB);
          m_res_dst = bus.dst;
        end else begin
          m_rem = (bus.op == 2'd2) ? 4 : 2;
          m_pend_res = m_eval(bus.op, bus.opA, bus.opB);
          m_pend_dst = bus.dst;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the clock edge.
  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      check("busy",    {63'd0, bus.busy}, {63'd0, (m_rem > 0)});
      check("done",    {63'd0, bus.done}, {63'd0, m_done});
      check("result",  bus.result, m_result);
      check("res_dst", {60'd0, bus.res_dst}, {60'd0, m_res_dst});
    end
  end

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] d);
    bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b; bus.dst = d;
  endtask

  function automatic logic [63:0] pick_operand();
    logic [31:0] tbl [0:4];
    logic [31:0] re, im;
    tbl[0] = 32'h0; tbl[1] = 32'h1; tbl[2] = 32'hFFFF_FFFF;
    tbl[3] = 32'h7FFF_FFFF; tbl[4] = 32'h8000_0000;
    re = ($urandom_range(0, 3) == 0) ? tbl[$urandom_range(0, 4)] : $urandom;
    im = ($urandom_range(0, 3) == 0) ? tbl[$urandom_range(0, 4)] : $urandom;
    return {re, im};
  endfunction

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.opA = 64'h0; bus.opB = 64'h0; bus.dst = 4'h0;
    reset = 1'b1;
    tick(); tick();
    check("rst_busy",   {63'd0, bus.busy}, 64'd0);
    check("rst_done",   {63'd0, bus.done}, 64'd0);
    check("rst_result", bus.result, 64'h0);
    check("rst_resdst", {60'd0, bus.res_dst}, 64'd0);
    chk_en = 1'b1;
    reset = 1'b0;
    tick();

    // ADD {3,4}+{1,-1} -> {4,3}
    issue(2'd0, 64'h00000003_00000004, 64'h00000001_FFFFFFFF, 4'd5);
    tick();
    bus.start = 1'b0;
    check("add_done",   {63'd0, bus.done}, 64'd1);
    check("add_result", bus.result, 64'h00000004_00000003);
    check("add_dst",    {60'd0, bus.res_dst}, 64'd5);

    // MUL {1,2}*{3,4} with an ADD request held during busy
    issue(2'd2, 64'h00000001_00000002, 64'h00000003_00000004, 4'd3);
    tick();
    check("mul_busy1", {63'd0, bus.busy}, 64'd1);
    issue(2'd0, 64'h00000005_00000006, 64'h00000001_00000001, 4'd9);
    tick();
    check("mul_nodone2", {63'd0, bus.done}, 64'd0);
    tick(); tick();
    check("mul_nodone4", {63'd0, bus.done}, 64'd0);
    check("mul_busy4",   {63'd0, bus.busy}, 64'd1);
    tick();
    check("mul_done",   {63'd0, bus.done}, 64'd1);
    check("mul_busy5",  {63'd0, bus.busy}, 64'd0);
    check("mul_result", bus.result, 64'hFFFFFFFB_0000000A);
    check("mul_dst",    {60'd0, bus.res_dst}, 64'd3);
    tick();
    bus.start = 1'b0;
    check("b2b_done",   {63'd0, bus.done}, 64'd1);
    check("b2b_result", bus.result, 64'h00000006_00000007);
    check("b2b_dst",    {60'd0, bus.res_dst}, 64'd9);

    // MAG {3,4} -> 25
    issue(2'd3, 64'h00000003_00000004, 64'h0, 4'd1);
    tick();
    bus.start = 1'b0;
    tick();
    check("mag_nodone", {63'd0, bus.done}, 64'd0);
    tick();
    check("mag_done",   {63'd0, bus.done}, 64'd1);
    check("mag_result", bus.result, 64'h00000019_00000000);

    // SUB {0,0}-{1,1}
    issue(2'd1, 64'h0, 64'h00000001_00000001, 4'd2);
    tick();
    bus.start = 1'b0;
    check("sub_result", bus.result, 64'hFFFFFFFF_FFFFFFFF);

    // Reset while the MUL sequence is in M2
    issue(2'd2, 64'h00000007_00000002, 64'h00000003_00000009, 4'd6);
    tick();
    bus.start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",   {63'd0, bus.busy}, 64'd0);
    check("abort_done",   {63'd0, bus.done}, 64'd0);
    check("abort_result", bus.result, 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_nodone", {63'd0, bus.done}, 64'd0);
    end
    issue(2'd0, 64'h00000010_00000020, 64'h00000001_00000002, 4'd4);
    tick();
    bus.start = 1'b0;
    check("fresh_result", bus.result, 64'h00000011_00000022);

    // Overflowing ADD
    issue(2'd0, 64'h7FFFFFFF_80000000, 64'h00000001_FFFFFFFF, 4'd7);
    tick();
    bus.start = 1'b0;
`ifdef CALU_SAT_EN
    check("ovf_result", bus.result, 64'h7FFFFFFF_80000000);
`else
    check("ovf_result", bus.result, 64'h80000000_7FFFFFFF);
`endif

    // Randomized traffic, including occasional resets
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 99) < 2);
      bus.start = ($urandom_range(0, 99) < 60);
      bus.op    = 2'($urandom_range(0, 3));
      bus.opA   = pick_operand();
      bus.opB   = pick_operand();
      bus.dst   = 4'($urandom_range(0, 15));
      tick();
    end
    reset = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
